fp_normalize_pipe: RTL and testbench

//  Two-stage pipelined post-add normaliser for the FP adder/subtractor datapath, parametrised in mantissa/exponent width.

---
 rtl/fp_normalize_pipe_if.sv | 35 +++
 rtl/fp_normalize_pipe.sv | 170 +++++++++++++++++
 tb/tb_fp_normalize_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_normalize_pipe_if.sv
// Handshake bundle for the post-add normaliser: operand in, normalised result out.
interface fp_normalize_pipe_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W:0]   in_sig;
  logic [EXP_W-1:0]  in_exp;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_sig;
  logic [EXP_W-1:0]  out_exp;
  logic [TAG_W-1:0]  out_tag;
  logic              out_zero;
  logic              out_denorm;
  logic              out_ovf;
  logic              out_inexact;

  // Producer of operands / consumer of results (the surrounding datapath or a bench).
  modport master (
    output in_valid, in_sig, in_exp, in_tag, out_ready,
    input  in_ready, out_valid, out_sig, out_exp, out_tag,
    input  out_zero, out_denorm, out_ovf, out_inexact
  );

  // The normaliser itself.
  modport slave (
    input  in_valid, in_sig, in_exp, in_tag, out_ready,
    output in_ready, out_valid, out_sig, out_exp, out_tag,
    output out_zero, out_denorm, out_ovf, out_inexact
  );
endinterface

// File: rtl/fp_normalize_pipe.sv
// Two-stage post-add normaliser. Stage 1 captures the raw sum and its leading
// zero count; stage 2 picks zero / carry right-shift / clamped left-shift and
// registers the result, which drives the outputs directly.
module fp_normalize_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              reset,
  fp_normalize_pipe_if.slave bus
);
  localparam int SH_W = $clog2(MANT_W + 1);
  // Exponent math runs one bit wider than the exponent so +1 never wraps.
  localparam int CW   = ((EXP_W + 1) > SH_W) ? (EXP_W + 1) : SH_W;
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] EXP_MAX_C = {{(CW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

  // Leading zeros of the mantissa field; MANT_W when the field is all zero.
  function automatic logic [SH_W-1:0] lzc_f(input logic [MANT_W-1:0] v);
    logic [SH_W-1:0] n;
    n = SH_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (v[i]) begin
        n = SH_W'(MANT_W - 1 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Stage 1 registers
  logic              s1_valid_q;
  logic [MANT_W:0]   s1_sig_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic              s1_carry_q;
  logic [SH_W-1:0]   s1_lzc_q;

  // Stage 2 (output) registers and their next-state values
  logic              out_valid_q,   out_valid_d;
  logic [MANT_W-1:0] out_sig_q,     out_sig_d;
  logic [EXP_W-1:0]  out_exp_q,     out_exp_d;
  logic [TAG_W-1:0]  out_tag_q,     out_tag_d;
  logic              out_zero_q,    out_zero_d;
  logic              out_denorm_q,  out_denorm_d;
  logic              out_ovf_q,     out_ovf_d;
  logic              out_inexact_q, out_inexact_d;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic [CW-1:0]     exp_ext_s;
  logic [CW-1:0]     exp_inc_s;
  logic [CW-1:0]     limit_s;
  logic [CW-1:0]     lzc_ext_s;
  logic [CW-1:0]     shift_s;
  logic              clamp_s;
  logic [EXP_W-1:0]  exp_sub_s;
  logic [MANT_W-1:0] mant_shl_s;

  // A stage moves when its slot is empty or the stage after it is moving.
  assign s2_adv_s     = !out_valid_q || bus.out_ready;
  assign s1_adv_s     = !s1_valid_q || s2_adv_s;
  assign bus.in_ready = s1_adv_s && !reset;

  // Left-shift is limited so the exponent never drops below 1; beyond that the result is subnormal.
  assign exp_ext_s  = CW'(s1_exp_q);
  assign exp_inc_s  = exp_ext_s + ONE_C;
  assign limit_s    = (exp_ext_s == ZERO_C) ? ZERO_C : (exp_ext_s - ONE_C);
  assign lzc_ext_s  = CW'(s1_lzc_q);
  assign clamp_s    = (lzc_ext_s > limit_s);
  assign shift_s    = clamp_s ? limit_s : lzc_ext_s;
  assign exp_sub_s  = EXP_W'(exp_ext_s - shift_s);
  assign mant_shl_s = s1_sig_q[MANT_W-1:0] << shift_s;

  // Stage 2 next state: hold on stall, otherwise classify and normalise the stage-1 operand.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_sig_d     = out_sig_q;
    out_exp_d     = out_exp_q;
    out_tag_d     = out_tag_q;
    out_zero_d    = out_zero_q;
    out_denorm_d  = out_denorm_q;
    out_ovf_d     = out_ovf_q;
    out_inexact_d = out_inexact_q;
    if (s2_adv_s && s1_valid_q) begin
      out_valid_d   = 1'b1;
      out_tag_d     = s1_tag_q;
      out_sig_d     = {MANT_W{1'b0}};
      out_exp_d     = {EXP_W{1'b0}};
      out_zero_d    = 1'b0;
      out_denorm_d  = 1'b0;
      out_ovf_d     = 1'b0;
      out_inexact_d = 1'b0;
      if (s1_sig_q == {(MANT_W+1){1'b0}}) begin
        out_zero_d = 1'b1;
      end else if (s1_carry_q) begin
        out_inexact_d = s1_sig_q[0];
        if (exp_inc_s >= EXP_MAX_C) begin
          out_ovf_d = 1'b1;
          out_exp_d = {EXP_W{1'b1}};
        end else begin
          out_sig_d = s1_sig_q[MANT_W:1];
          out_exp_d = exp_inc_s[EXP_W-1:0];
        end
      end else begin
        out_sig_d = mant_shl_s;
        if (clamp_s) begin
          out_denorm_d = 1'b1;
        end else begin
          out_exp_d = exp_sub_s;
        end
      end
    end else if (s2_adv_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous reset discarding anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_sig_q      <= {(MANT_W+1){1'b0}};
      s1_exp_q      <= {EXP_W{1'b0}};
      s1_tag_q      <= {TAG_W{1'b0}};
      s1_carry_q    <= 1'b0;
      s1_lzc_q      <= {SH_W{1'b0}};
      out_valid_q   <= 1'b0;
      out_sig_q     <= {MANT_W{1'b0}};
      out_exp_q     <= {EXP_W{1'b0}};
      out_tag_q     <= {TAG_W{1'b0}};
      out_zero_q    <= 1'b0;
      out_denorm_q  <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sig_q   <= bus.in_sig;
          s1_exp_q   <= bus.in_exp;
          s1_tag_q   <= bus.in_tag;
          s1_carry_q <= bus.in_sig[MANT_W];
          s1_lzc_q   <= lzc_f(bus.in_sig[MANT_W-1:0]);
        end
      end
      out_valid_q   <= out_valid_d;
      out_sig_q     <= out_sig_d;
      out_exp_q     <= out_exp_d;
      out_tag_q     <= out_tag_d;
      out_zero_q    <= out_zero_d;
      out_denorm_q  <= out_denorm_d;
      out_ovf_q     <= out_ovf_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_sig     = out_sig_q;
  assign bus.out_exp     = out_exp_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_denorm  = out_denorm_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_inexact = out_inexact_q;
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe (MANT_W=24, EXP_W=8, TAG_W=4): directed vector
// table, latency/stall/reset sequences and randomized traffic against a model.
module tb_fp_normalize_pipe;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int TW = 4;

  typedef struct packed {
    logic [MW-1:0] sig;
    logic [EW-1:0] exp;
    logic [TW-1:0] tag;
    logic          zero;
    logic          denorm;
    logic          ovf;
    logic          inexact;
  } res_t;

  typedef struct {
    logic [MW:0]   sig;
    logic [EW-1:0] exp;
    res_t          want;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_normalize_pipe_if #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) bus ();

  fp_normalize_pipe #(.MANT_W(MW), .EXP_W(EW), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  res_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   accepted = 0;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference: normalise by repeated doubling while the exponent can still drop.
  function automatic res_t ref_model(input logic [MW:0] s, input logic [EW-1:0] e, input logic [TW-1:0] t);
    res_t r;
    int   m;
    int   ex;
    r = '0;
    r.tag = t;
    if (s == 25'h0) begin
      r.zero = 1'b1;
    end else if (s[MW]) begin
      ex = int'(e) + 1;
      r.inexact = s[0];
      if (ex >= 255) begin
        r.ovf = 1'b1;
        r.exp = 8'hFF;
      end else begin
        r.sig = s[MW:1];
        r.exp = 8'(ex);
      end
    end else begin
      m  = int'(s[MW-1:0]);
      ex = int'(e);
      while (m < (1 << (MW - 1)) && ex > 1) begin
        m  = m * 2;
        ex = ex - 1;
      end
      if (m < (1 << (MW - 1))) begin
        r.denorm = 1'b1;
        r.exp    = 8'h00;
      end else begin
        r.exp = 8'(ex);
      end
      r.sig = 24'(m);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [MW:0] s, input logic [EW-1:0] e, input logic [TW-1:0] t,
                              input logic [MW-1:0] osig, input logic [EW-1:0] oexp,
                              input logic z, input logic d, input logic o, input logic i);
    vec_t v;
    v.sig = s;
    v.exp = e;
    v.want.sig = osig;
    v.want.exp = oexp;
    v.want.tag = t;
    v.want.zero = z;
    v.want.denorm = d;
    v.want.ovf = o;
    v.want.inexact = i;
    return v;
  endfunction

  // Present one operand and hold it until accepted (bounded), recording its expected result.
  task automatic send_one(input logic [MW:0] s, input logic [EW-1:0] e, input res_t want);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sig   = s;
    bus.in_exp   = e;
    bus.in_tag   = want.tag;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(want);
        accepted++;
        done = 1'b1;
      end else if (n > 60) begin
        check("send_timeout", 64'(0), 64'(1));
        done = 1'b1;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Compare every completed output transfer against the head of the expected queue.
  task automatic monitor();
    res_t got;
    res_t want;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got.sig = bus.out_sig;
        got.exp = bus.out_exp;
        got.tag = bus.out_tag;
        got.zero = bus.out_zero;
        got.denorm = bus.out_denorm;
        got.ovf = bus.out_ovf;
        got.inexact = bus.out_inexact;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(got), 64'(0));
          if (got == '0) check("unexpected_output", 64'(1), 64'(0));
        end else begin
          want = exp_q.pop_front();
          check("result", 64'(got), 64'(want));
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [MW:0]   rs;
    logic [EW-1:0] re;
    int            base;
    bit            rand_done;

    vecs[0]  = mk(25'h0800000, 8'h80, 4'h1, 24'h800000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(25'h1800001, 8'h80, 4'h2, 24'hC00000, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(25'h0000001, 8'h80, 4'h3, 24'h800000, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(25'h0000000, 8'h80, 4'h4, 24'h000000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(25'h0000100, 8'h05, 4'h5, 24'h001000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(25'h0000100, 8'h00, 4'h6, 24'h000100, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(25'h1000000, 8'hFE, 4'h7, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mk(25'h1000001, 8'hFE, 4'h8, 24'h000000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[8]  = mk(25'h1FFFFFF, 8'hFD, 4'h9, 24'hFFFFFF, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs[9]  = mk(25'h0800000, 8'h00, 4'hA, 24'h800000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(25'h0400000, 8'h01, 4'hB, 24'h400000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(25'h0400000, 8'h02, 4'hC, 24'h800000, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(25'h1000000, 8'hFD, 4'hD, 24'h800000, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

    bus.in_valid  = 1'b0;
    bus.in_sig    = 25'h0;
    bus.in_exp    = 8'h0;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_sig", 64'(bus.out_sig), 64'(0));
    check("rst_out_exp", 64'(bus.out_exp), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));
    check("rst_flags", 64'({bus.out_zero, bus.out_denorm, bus.out_ovf, bus.out_inexact}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed table, back to back
    for (int i = 0; i < 13; i++) begin
      send_one(vecs[i].sig, vecs[i].exp, vecs[i].want);
    end
    drain();

    // Latency: result visible after the second edge following acceptance
    send_one(vecs[0].sig, vecs[0].exp, vecs[0].want);
    @(negedge clk);
    check("latency_1cyc_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    check("latency_2cyc_valid", 64'(bus.out_valid), 64'(1));
    drain();

    // Stall: four tagged ops while the consumer is blocked for five cycles
    base = accepted;
    fork
      begin
        for (int t = 1; t <= 4; t++) begin
          rs = 25'h0800000 | 25'(t);
          send_one(rs, 8'h80, ref_model(rs, 8'h80, 4'(t)));
        end
      end
      begin
        bus.out_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("stall_accepted", 64'(accepted - base), 64'(2));
        check("stall_in_ready", 64'(bus.in_ready), 64'(0));
        check("stall_out_valid", 64'(bus.out_valid), 64'(1));
        check("stall_out_tag", 64'(bus.out_tag), 64'(1));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two operands in flight: both discarded
    bus.out_ready = 1'b0;
    send_one(25'h0123456, 8'h40, ref_model(25'h0123456, 8'h40, 4'hE));
    send_one(25'h1234567, 8'h40, ref_model(25'h1234567, 8'h40, 4'hF));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_quiet", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          case ($urandom_range(0, 9))
            0:       rs = 25'h0;
            1, 2, 3: rs = {1'b1, 24'($urandom)};
            default: rs = {1'b0, 24'($urandom) >> $urandom_range(0, 24)};
          endcase
          case ($urandom_range(0, 5))
            0:       re = 8'h00;
            1:       re = 8'h01;
            2:       re = 8'hFE;
            3:       re = 8'hFF;
            default: re = 8'($urandom);
          endcase
          send_one(rs, re, ref_model(rs, re, 4'($urandom)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
